reg_file_2r1w: RTL and testbench

- Parametrised ARM-style register file: NUM_REGS = 2**ADDR_W registers, DATA_W bits each.
- Two independent read ports (A, B), one synchronous write port, and a program-counter register at index PC_IDX with auto-increment.
- Generalises the 16:1 read multiplexer into a full storage block with optional write-bypass and optional registered read outputs.
- Sits between decode (register addresses) and the ALU/operand latch.

---
 rtl/reg_file_2r1w.sv | 86 ++++++++
 tb/tb_reg_file_2r1w.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Register file with two independent read ports, one write port and an
// auto-incrementing program counter, with optional write bypass and read register.
module reg_file_2r1w #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PC_IDX  = 15,
  parameter int PC_INC  = 4,
  parameter int REG_OUT = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic              rd_valid,
  input  logic              pc_inc_en,
  output logic [DATA_W-1:0] pc_out
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(PC_INC);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              pc_written;

  assign pc_written = we && (wa == PC_ADDR);

  // NOTE: every register is cleared on reset so no X can ever reach the read
  // ports; this forces flops rather than RAM macros, which is intended here.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (we) regs[wa] <= wd;
      // An explicit write to the PC wins over the increment.
      if (pc_inc_en && !pc_written) regs[PC_ADDR] <= regs[PC_ADDR] + PC_STEP;
    end
  end

  // NOTE: defaults are assigned first so no path through the block can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    sel_a = regs[ra_a];
    sel_b = regs[ra_b];
    if (BYPASS != 0 && we) begin
      if (wa == ra_a) sel_a = wd;
      if (wa == ra_b) sel_b = wd;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rd_a     <= '0;
          rd_b     <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= re;
          if (re) begin
            rd_a <= sel_a;
            rd_b <= sel_b;
          end
        end
      end
    end else begin : g_comb_out
      assign rd_a     = sel_a;
      assign rd_b     = sel_b;
      assign rd_valid = re;
    end
  endgenerate

  assign pc_out = regs[PC_ADDR];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench: a combinational/bypass instance and a registered/no-bypass
// instance share stimulus and are compared against an array-based model.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        re;
  logic [3:0]  ra_a;
  logic [3:0]  ra_b;
  logic        pc_inc_en;

  logic [31:0] rd_a, rd_b, pc_out;
  logic        rd_valid;
  logic [31:0] rd_a_r, rd_b_r, pc_out_r;
  logic        rd_valid_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.REG_OUT(0), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b), .rd_valid(rd_valid),
    .pc_inc_en(pc_inc_en), .pc_out(pc_out)
  );

  reg_file_2r1w #(.REG_OUT(1), .BYPASS(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a_r), .rd_b(rd_b_r), .rd_valid(rd_valid_r),
    .pc_inc_en(pc_inc_en), .pc_out(pc_out_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain array of register contents plus the registered-port view.
  logic [31:0] mdl [16];
  logic [31:0] mdl_r_a = '0, mdl_r_b = '0;
  logic        mdl_r_v = 1'b0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdl_r_a  = '0;
      mdl_r_b  = '0;
      mdl_r_v  = 1'b0;
      model_ok = 1'b1;
    end else begin
      mdl_r_v = re;
      if (re) begin
        mdl_r_a = mdl[ra_a];
        mdl_r_b = mdl[ra_b];
      end
      if (pc_inc_en && !(we && wa == 4'd15)) mdl[15] = mdl[15] + 32'd4;
      if (we) mdl[wa] = wd;
    end
  end

  // Compare process: every negative edge once the model has seen a reset.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_rd_a",     rd_a, (we && wa == ra_a) ? wd : mdl[ra_a]);
      check("cmp_rd_b",     rd_b, (we && wa == ra_b) ? wd : mdl[ra_b]);
      check("cmp_valid",    {31'd0, rd_valid}, {31'd0, re});
      check("cmp_pc",       pc_out, mdl[15]);
      check("cmp_r_rd_a",   rd_a_r, mdl_r_a);
      check("cmp_r_rd_b",   rd_b_r, mdl_r_b);
      check("cmp_r_valid",  {31'd0, rd_valid_r}, {31'd0, mdl_r_v});
      check("cmp_r_pc",     pc_out_r, mdl[15]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; re = 1'b0;
    ra_a = '0; ra_b = '0; pc_inc_en = 1'b0;

    // Reset for two edges, then read with both ports.
    tick(); tick();
    reset_n = 1'b1; re = 1'b1; ra_a = 4'd3; ra_b = 4'd15;
    @(negedge clk);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_rd_b", rd_b, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid_comb", {31'd0, rd_valid}, 32'd1);
    check("rst_valid_reg_c0", {31'd0, rd_valid_r}, 32'd0);
    tick();
    @(negedge clk);
    check("rst_valid_reg_c1", {31'd0, rd_valid_r}, 32'd1);
    check("rst_rd_a_reg", rd_a_r, 32'h0);
    re = 1'b0;

    // Write 0..14 and read back pairs (i, 14-i).
    for (int i = 0; i < 15; i++) write_reg(4'(i), 32'hF0F0F0F0 + 32'(i));
    re = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ra_a = 4'(i); ra_b = 4'(14 - i);
      @(negedge clk);
      check("wr_rd_a", rd_a, 32'hF0F0F0F0 + 32'(i));
      check("wr_rd_b", rd_b, 32'hF0F0F0F0 + 32'(14 - i));
      tick();
      @(negedge clk);
      check("wr_rd_a_reg", rd_a_r, 32'hF0F0F0F0 + 32'(i));
    end
    ra_a = 4'd15;
    @(negedge clk);
    check("pc_untouched", rd_a, 32'h0);
    check("pc_out_zero", pc_out, 32'h0);

    // Bypass collision: BYPASS=1 sees wd, BYPASS=0 sees the stored value.
    write_reg(4'd5, 32'h11111111);
    we = 1'b1; wa = 4'd5; wd = 32'hDEADBEEF; ra_a = 4'd5; re = 1'b1;
    @(negedge clk);
    check("bypass_comb", rd_a, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("nobypass_reg", rd_a_r, 32'h11111111);
    check("after_write_comb", rd_a, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("after_write_reg", rd_a_r, 32'hDEADBEEF);
    re = 1'b0;

    // PC increment, write priority and wrap.
    pc_inc_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      check("pc_inc", pc_out, 32'(4 * k));
    end
    we = 1'b1; wa = 4'd15; wd = 32'h100;
    tick();
    @(negedge clk);
    check("pc_write_prio", pc_out, 32'h100);
    pc_inc_en = 1'b0; wd = 32'hFFFFFFFC;
    tick();
    we = 1'b0; pc_inc_en = 1'b1; re = 1'b1; ra_a = 4'd15;
    @(negedge clk);
    check("pc_read_pre_inc", rd_a, 32'hFFFFFFFC);
    tick();
    @(negedge clk);
    check("pc_wrap", pc_out, 32'h0);
    pc_inc_en = 1'b0; re = 1'b0;

    // Registered read captures, then holds while re is low.
    write_reg(4'd2, 32'hA5A5A5A5);
    re = 1'b1; ra_a = 4'd2;
    tick();
    @(negedge clk);
    check("reg_capture", rd_a_r, 32'hA5A5A5A5);
    check("reg_valid_hi", {31'd0, rd_valid_r}, 32'd1);
    re = 1'b0; ra_a = 4'd7;
    tick();
    @(negedge clk);
    check("reg_hold", rd_a_r, 32'hA5A5A5A5);
    check("reg_valid_lo", {31'd0, rd_valid_r}, 32'd0);

    // Mid-operation reset discards the write, increment and pending read.
    write_reg(4'd1, 32'h77);
    pc_inc_en = 1'b1; tick(); tick();
    re = 1'b1; ra_a = 4'd1;
    reset_n = 1'b0; we = 1'b1; wa = 4'd1; wd = 32'h55;
    tick();
    reset_n = 1'b1; we = 1'b0; pc_inc_en = 1'b0; re = 1'b0;
    @(negedge clk);
    check("midrst_reg1", rd_a, 32'h0);
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_valid", {31'd0, rd_valid_r}, 32'd0);
    check("midrst_rd_a_reg", rd_a_r, 32'h0);
    write_reg(4'd1, 32'h55);
    @(negedge clk);
    check("resume_reg1", rd_a, 32'h55);

    // Randomised traffic, biased towards collisions and PC accesses.
    for (int n = 0; n < 3000; n++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      we        = $urandom_range(0, 1) == 1;
      wa        = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      wd        = $urandom;
      if ($urandom_range(0, 15) == 0) wd = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      re        = $urandom_range(0, 3) != 0;
      ra_a      = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      ra_b      = ($urandom_range(0, 3) == 0) ? ra_a : 4'($urandom_range(0, 15));
      pc_inc_en = $urandom_range(0, 1) == 1;
      tick();
    end
    reset_n = 1'b1; we = 1'b0; re = 1'b0; pc_inc_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
